// File: rtl/mem_pkg.sv
// Shared definitions for the M-stage memory access unit: op field layout,
// access sizes, exception codes and the alignment rule.
package mem_pkg;

   localparam int OP_STORE = 3;
   localparam int OP_UNS   = 2;
   localparam int OP_SZ_HI = 1;
   localparam int OP_SZ_LO = 0;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam logic [1:0] EXC_NONE = 2'd0;
   localparam logic [1:0] EXC_ADEL = 2'd1;
   localparam logic [1:0] EXC_ADES = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MEM,
      ST_RESP
   } state_t;

   function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] addr_lo);
      logic ok;
      case (size)
         SZ_B:    ok = 1'b1;
         SZ_H:    ok = (addr_lo[0] == 1'b0);
         SZ_W:    ok = (addr_lo[1:0] == 2'b00);
         default: ok = (addr_lo == 3'b000);
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: write enables, store data placement and
// load data extraction with sign/zero extension.
module mem_lane_align
   import mem_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [1:0]              size,
   input  logic                    is_unsigned,
   input  logic [$clog2(DW/8)-1:0] offset,
   input  logic [DW-1:0]           wdata,
   input  logic [DW-1:0]           rdata,
   output logic [DW/8-1:0]         byteen,
   output logic [DW-1:0]           wdata_lane,
   output logic [DW-1:0]           rdata_ext
);

   localparam int NB = DW / 8;
   localparam int IW = $clog2(DW);

   logic [NB-1:0] base_mask;
   logic [DW-1:0] wsh;
   logic [DW-1:0] rsh;
   logic [IW-1:0] sign_idx;
   logic          fill;
   int            nbits;

   always_comb begin
      case (size)
         SZ_B:    base_mask = NB'(1);
         SZ_H:    base_mask = NB'(3);
         SZ_W:    base_mask = NB'(15);
         default: base_mask = '1;
      endcase
      byteen = base_mask << offset;

      wsh = wdata << {offset, 3'b000};
      for (int i = 0; i < NB; i++) begin
         wdata_lane[8*i +: 8] = wsh[8*i +: 8] & {8{byteen[i]}};
      end
   end

   // A full-width access takes every bit from the shifted word, so the
   // is_unsigned fill never appears in that case.
   always_comb begin
      rsh   = rdata >> {offset, 3'b000};
      nbits = 8 << size;
      if (nbits > DW) nbits = DW;
      sign_idx = IW'(nbits - 1);
      fill     = ~is_unsigned & rsh[sign_idx];
      for (int i = 0; i < DW; i++) begin
         rdata_ext[i] = (i < nbits) ? rsh[i] : fill;
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// Registered, handshaked M-stage memory access unit with address-error
// detection; FSM IDLE -> MEM -> RESP, or IDLE -> RESP on an exception.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [AW-1:0]     req_addr,
   input  logic [DW-1:0]     req_wdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [DW/8-1:0]   mem_byteen,
   output logic [DW-1:0]     mem_wdata,
   input  logic [DW-1:0]     mem_rdata,
   input  logic              mem_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DW-1:0]     rsp_rdata,
   output logic [1:0]        rsp_exc
);

   localparam int NB = DW / 8;
   localparam int OW = $clog2(NB);

   state_t          state, state_next;
   logic            store_q, uns_q;
   logic [1:0]      size_q;
   logic [OW-1:0]   off_q;

   logic            store_next, uns_next;
   logic [1:0]      size_next;
   logic [OW-1:0]   off_next;
   logic            req_ready_next, mem_en_next, mem_we_next, rsp_valid_next;
   logic [AW-1:0]   mem_addr_next;
   logic [NB-1:0]   mem_byteen_next;
   logic [DW-1:0]   mem_wdata_next, rsp_rdata_next;
   logic [1:0]      rsp_exc_next;

   logic [1:0]      lane_size;
   logic            lane_uns;
   logic [OW-1:0]   lane_off;
   logic [NB-1:0]   lane_byteen;
   logic [DW-1:0]   lane_wdata, lane_rdata;
   logic            req_store, req_legal;

   assign req_store = req_op[OP_STORE];
   assign req_legal = is_aligned(req_op[OP_SZ_HI:OP_SZ_LO], req_addr[2:0]) &&
                      !(req_op[OP_SZ_HI:OP_SZ_LO] == SZ_D && DW == 32);

   // In IDLE the lanes are computed from the incoming request so the memory
   // outputs can be registered at accept; afterwards from the captured op.
   always_comb begin
      if (state == ST_IDLE) begin
         lane_size = req_op[OP_SZ_HI:OP_SZ_LO];
         lane_uns  = req_op[OP_UNS];
         lane_off  = req_addr[OW-1:0];
      end else begin
         lane_size = size_q;
         lane_uns  = uns_q;
         lane_off  = off_q;
      end
   end

   mem_lane_align #(.DW(DW)) u_align (
      .size        (lane_size),
      .is_unsigned (lane_uns),
      .offset      (lane_off),
      .wdata       (req_wdata),
      .rdata       (mem_rdata),
      .byteen      (lane_byteen),
      .wdata_lane  (lane_wdata),
      .rdata_ext   (lane_rdata)
   );

   always_comb begin
      state_next      = state;
      store_next      = store_q;
      uns_next        = uns_q;
      size_next       = size_q;
      off_next        = off_q;
      req_ready_next  = req_ready;
      mem_en_next     = mem_en;
      mem_we_next     = mem_we;
      mem_addr_next   = mem_addr;
      mem_byteen_next = mem_byteen;
      mem_wdata_next  = mem_wdata;
      rsp_valid_next  = rsp_valid;
      rsp_rdata_next  = rsp_rdata;
      rsp_exc_next    = rsp_exc;
      case (state)
         ST_IDLE: begin
            req_ready_next = 1'b1;
            if (req_valid && req_ready) begin
               req_ready_next = 1'b0;
               store_next     = req_store;
               uns_next       = req_op[OP_UNS];
               size_next      = req_op[OP_SZ_HI:OP_SZ_LO];
               off_next       = req_addr[OW-1:0];
               if (req_legal) begin
                  state_next      = ST_MEM;
                  mem_en_next     = 1'b1;
                  mem_we_next     = req_store;
                  mem_addr_next   = {req_addr[AW-1:OW], {OW{1'b0}}};
                  mem_byteen_next = lane_byteen;
                  mem_wdata_next  = req_store ? lane_wdata : '0;
               end else begin
                  state_next     = ST_RESP;
                  rsp_valid_next = 1'b1;
                  rsp_rdata_next = '0;
                  rsp_exc_next   = req_store ? EXC_ADES : EXC_ADEL;
               end
            end
         end
         ST_MEM: begin
            if (mem_ready) begin
               state_next      = ST_RESP;
               mem_en_next     = 1'b0;
               mem_we_next     = 1'b0;
               mem_addr_next   = '0;
               mem_byteen_next = '0;
               mem_wdata_next  = '0;
               rsp_valid_next  = 1'b1;
               rsp_exc_next    = EXC_NONE;
               rsp_rdata_next  = store_q ? '0 : lane_rdata;
            end
         end
         default: begin
            if (rsp_ready) begin
               state_next     = ST_IDLE;
               rsp_valid_next = 1'b0;
               rsp_rdata_next = '0;
               rsp_exc_next   = EXC_NONE;
               req_ready_next = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         store_q    <= 1'b0;
         uns_q      <= 1'b0;
         size_q     <= SZ_B;
         off_q      <= '0;
         req_ready  <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_byteen <= '0;
         mem_wdata  <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_exc    <= EXC_NONE;
      end else begin
         state      <= state_next;
         store_q    <= store_next;
         uns_q      <= uns_next;
         size_q     <= size_next;
         off_q      <= off_next;
         req_ready  <= req_ready_next;
         mem_en     <= mem_en_next;
         mem_we     <= mem_we_next;
         mem_addr   <= mem_addr_next;
         mem_byteen <= mem_byteen_next;
         mem_wdata  <= mem_wdata_next;
         rsp_valid  <= rsp_valid_next;
         rsp_rdata  <= rsp_rdata_next;
         rsp_exc    <= rsp_exc_next;
      end
   end

endmodule
